// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises one read or write frame per command on MDC/MDIO.
// Build option MDIO_PRE_SUPPRESS_EN: only the first frame after reset carries the 32-bit preamble.
module mdio_master #(
  parameter int MDC_DIV = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(MDC_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  div;
  logic        phase;
  logic [5:0]  bit_cnt;
  logic [31:0] tx, tx_src, frame_in;
  logic [15:0] rx;
  logic [1:0]  sync;
  logic        wr, wr_src, fin;
  logic        accept, tick, rise, fall;
  logic        launch, shift, drv_o, drv_oe, pre_needed;

  assign accept = cmd_valid & cmd_ready;
  assign tick   = (state != IDLE) && (div == DIV_LAST);
  assign rise   = tick & ~phase;
  assign fall   = tick & phase;
  assign busy   = (state != IDLE);
  // DONE keeps the divider running to time its idle period but never shows it on the pin
  assign mdc    = phase & (state != DONE);

  // everything after the preamble as one word; read TA/data bits are don't-care since oe=0
  assign frame_in = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                     cmd_write ? 2'b10 : 2'b11, cmd_write ? cmd_wdata : 16'hFFFF};

`ifdef MDIO_PRE_SUPPRESS_EN
  logic pre_done;
  assign pre_needed = ~pre_done;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pre_done <= 1'b0;
    else if (accept) pre_done <= 1'b1;
  end
`else
  assign pre_needed = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = pre_needed ? PRE : HDR;
      PRE:  if (fall && bit_cnt == 6'd31) state_nxt = HDR;
      HDR:  if (fall && bit_cnt == 6'd13) state_nxt = TA;
      TA:   if (fall && bit_cnt == 6'd1)  state_nxt = DATA;
      DATA: if (fall && bit_cnt == 6'd15) state_nxt = DONE;
      DONE: if (rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // a new bit is launched on accept and on every MDC falling cycle
  always_comb begin
    launch = (state == IDLE) ? accept : (fall && state != DONE);
    tx_src = (state == IDLE) ? frame_in : tx;
    wr_src = (state == IDLE) ? cmd_write : wr;
    drv_o  = 1'b1;
    drv_oe = 1'b0;
    shift  = 1'b0;
    case (state_nxt)
      PRE: drv_oe = 1'b1;
      HDR: begin
        drv_o  = tx_src[31];
        drv_oe = 1'b1;
        shift  = launch;
      end
      TA, DATA: begin
        drv_o  = tx_src[31];
        drv_oe = wr_src;
        shift  = launch;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      fin     <= 1'b0;
    end else begin
      if (state == IDLE) begin
        div   <= '0;
        phase <= 1'b0;
      end else if (tick) begin
        div   <= '0;
        phase <= ~phase;
      end else begin
        div <= div + 8'd1;
      end
      if (state_nxt != state) bit_cnt <= '0;
      else if (fall)          bit_cnt <= bit_cnt + 6'd1;
      if (state != DONE) fin <= 1'b0;
      else if (fall)     fin <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx        <= '0;
      wr        <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rx        <= '0;
      sync      <= '0;
    end else begin
      sync      <= {sync[0], mdio_i};
      cmd_ready <= (state_nxt == IDLE);
      if (accept) wr <= cmd_write;
      if (shift)       tx <= {tx_src[30:0], 1'b0};
      else if (accept) tx <= frame_in;
      if (launch) begin
        mdio_o  <= drv_o;
        mdio_oe <= drv_oe;
      end
      if (state == DATA && rise) rx <= {rx[14:0], sync[1]};
      // one cycle after the DONE idle period ends; ready only rises after this pulse
      rsp_valid <= (state == DONE) && fin && !rsp_valid;
      if (state == DONE && fin && !rsp_valid && !wr) rsp_rdata <= rx;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: two instances (MDC_DIV 4 and 25), a PHY model and a frame/timing monitor.
module tb_mdio_master;
  localparam int NU = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid[NU], cmd_ready[NU], cmd_write[NU];
  logic [4:0]  cmd_phy[NU], cmd_reg[NU];
  logic [15:0] cmd_wdata[NU];
  logic        rsp_valid[NU];
  logic [15:0] rsp_rdata[NU];
  logic        busy[NU], mdc[NU], mdio_o[NU], mdio_oe[NU], mdio_i[NU];

  int checks = 0, failures = 0;

  // monitor state
  logic [63:0] cap_o[NU], cap_oe[NU];
  int   nrise[NU], runc[NU], lowrun[NU], first_low[NU];
  int   terr[NU] = '{0, 0};
  int   rsp_cnt[NU] = '{0, 0};
  logic pm[NU], po[NU], poe[NU], pb[NU];

  // reference-model state
  logic [15:0] phy_data[NU];
  int          phy_len[NU];
  bit          pre_sent[NU];
  logic [15:0] last_rd[NU];

  for (genvar g = 0; g < NU; g++) begin : u
    mdio_master #(.MDC_DIV(g == 0 ? 4 : 25)) dut (
      .clk(clk), .reset(rst),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_phy_addr(cmd_phy[g]), .cmd_reg_addr(cmd_reg[g]), .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .busy(busy[g]),
      .mdc(mdc[g]), .mdio_o(mdio_o[g]), .mdio_oe(mdio_oe[g]), .mdio_i(mdio_i[g]));
  end

  function automatic int dv(input int g);
    return (g == 0) ? 4 : 25;
  endfunction

  // PHY answers a read in the last 16 MDC periods of the frame, MSB first
  function automatic logic phy_bit(input int g, input int idx);
    int ds;
    ds = phy_len[g] - 16;
    if (idx >= ds && idx < ds + 16) return phy_data[g][15 - (idx - ds)];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < NU; g++) begin
      pm[g] <= mdc[g]; po[g] <= mdio_o[g]; poe[g] <= mdio_oe[g]; pb[g] <= busy[g];
      lowrun[g] <= mdc[g] ? 0 : lowrun[g] + 1;
      if (rsp_valid[g]) rsp_cnt[g] <= rsp_cnt[g] + 1;
      if (rst) begin
        nrise[g] <= 0; cap_o[g] <= '0; cap_oe[g] <= '0; mdio_i[g] <= 1'b0; runc[g] <= 1;
      end else if (busy[g] && !pb[g]) begin
        nrise[g] <= 0; cap_o[g] <= '0; cap_oe[g] <= '0; runc[g] <= 1;
      end else begin
        runc[g] <= (mdc[g] != pm[g]) ? 1 : runc[g] + 1;
        if (mdc[g] != pm[g] && runc[g] != dv(g))
          terr[g] <= terr[g] + 1;
        else if (!(pm[g] && !mdc[g]) && (mdio_o[g] != po[g] || mdio_oe[g] != poe[g]))
          terr[g] <= terr[g] + 1;
        if (mdc[g] && !pm[g]) begin
          cap_o[g]  <= {cap_o[g][62:0], mdio_o[g]};
          cap_oe[g] <= {cap_oe[g][62:0], mdio_oe[g]};
          nrise[g]  <= nrise[g] + 1;
          if (nrise[g] == 0) first_low[g] <= lowrun[g];
        end
        if (!mdc[g] && pm[g]) mdio_i[g] <= phy_bit(g, nrise[g]);
      end
    end
  end

  task automatic do_cmd(input int ui, input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input bit now, input bit hold, input bit nwr,
                        input logic [4:0] npa, input logic [4:0] nra, input logic [15:0] nwd,
                        input string nm);
    int t, len, lat, nbad;
    logic [31:0] h, hoe;
    logic [63:0] eo, eoe;
    logic [15:0] erd;
    if (!now) @(negedge clk);
`ifdef MDIO_PRE_SUPPRESS_EN
    len = pre_sent[ui] ? 32 : 64;
`else
    len = 64;
`endif
    phy_len[ui] = len;
    if (!wr) phy_data[ui] = wd;
    cmd_valid[ui] = 1'b1; cmd_write[ui] = wr; cmd_phy[ui] = pa; cmd_reg[ui] = ra; cmd_wdata[ui] = wd;
    t = 0;
    while (cmd_ready[ui] !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    if (cmd_ready[ui] !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s accept: cmd_ready=%b required 1", nm, cmd_ready[ui]);
      cmd_valid[ui] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    pre_sent[ui] = 1'b1;
    if (hold) begin
      cmd_write[ui] = nwr; cmd_phy[ui] = npa; cmd_reg[ui] = nra; cmd_wdata[ui] = nwd;
    end else begin
      cmd_valid[ui] = 1'b0; cmd_write[ui] = 1'($urandom);
      cmd_phy[ui] = 5'($urandom); cmd_reg[ui] = 5'($urandom); cmd_wdata[ui] = 16'($urandom);
    end
    @(negedge clk);
    checks++;
    if (busy[ui] !== 1'b1 || cmd_ready[ui] !== 1'b0) begin
      failures++;
      $display("FAIL %s after_accept: busy=%b ready=%b required 1/0", nm, busy[ui], cmd_ready[ui]);
    end
    lat = 0; nbad = 0;
    while (rsp_valid[ui] !== 1'b1 && lat < 20000) begin
      @(negedge clk); lat++;
      if (cmd_ready[ui] !== 1'b0) nbad++;
    end
    checks++;
    if (lat != (len + 1) * 2 * dv(ui) + 1) begin
      failures++;
      $display("FAIL %s latency: got %0d required %0d", nm, lat, (len + 1) * 2 * dv(ui) + 1);
    end
    checks++;
    if (nbad != 0) begin
      failures++;
      $display("FAIL %s ready_while_busy: %0d cycles high, required 0", nm, nbad);
    end
    h   = {2'b01, wr ? 2'b01 : 2'b10, pa, ra, wr ? 2'b10 : 2'b00, wr ? wd : 16'h0000};
    hoe = {14'h3FFF, wr ? 18'h3FFFF : 18'h00000};
    eo  = (len == 64) ? {32'hFFFF_FFFF, h}   : {32'h0, h};
    eoe = (len == 64) ? {32'hFFFF_FFFF, hoe} : {32'h0, hoe};
    checks++;
    if (nrise[ui] !== len) begin
      failures++;
      $display("FAIL %s mdc_periods: got %0d required %0d", nm, nrise[ui], len);
    end
    checks++;
    if (cap_oe[ui] !== eoe) begin
      failures++;
      $display("FAIL %s oe_stream: got %h required %h", nm, cap_oe[ui], eoe);
    end
    checks++;
    if ((cap_o[ui] & eoe) !== (eo & eoe)) begin
      failures++;
      $display("FAIL %s mdio_stream: got %h required %h", nm, cap_o[ui] & eoe, eo & eoe);
    end
    erd = wr ? last_rd[ui] : wd;
    checks++;
    if (rsp_rdata[ui] !== erd) begin
      failures++;
      $display("FAIL %s rdata: got %h required %h", nm, rsp_rdata[ui], erd);
    end
    if (!wr) last_rd[ui] = wd;
    @(negedge clk);
    checks++;
    if (rsp_valid[ui] !== 1'b0 || cmd_ready[ui] !== 1'b1 || busy[ui] !== 1'b0) begin
      failures++;
      $display("FAIL %s after_rsp: rsp=%b ready=%b busy=%b required 0/1/0",
               nm, rsp_valid[ui], cmd_ready[ui], busy[ui]);
    end
  endtask

  task automatic cmd(input int ui, input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                     input logic [15:0] wd, input string nm);
    do_cmd(ui, wr, pa, ra, wd, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'd0, nm);
  endtask

  task automatic model_reset();
    for (int g = 0; g < NU; g++) begin pre_sent[g] = 1'b0; last_rd[g] = 16'h0000; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int g = 0; g < NU; g++) begin
      checks++;
      if (cmd_ready[g] !== 1'b0 || mdc[g] !== 1'b0 || mdio_o[g] !== 1'b1 || mdio_oe[g] !== 1'b0 ||
          busy[g] !== 1'b0 || rsp_valid[g] !== 1'b0 || rsp_rdata[g] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_values u%0d: ready=%b mdc=%b o=%b oe=%b busy=%b rsp=%b rdata=%h required 0,0,1,0,0,0,0000",
                 g, cmd_ready[g], mdc[g], mdio_o[g], mdio_oe[g], busy[g], rsp_valid[g], rsp_rdata[g]);
      end
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int g = 0; g < NU; g++) begin
      checks++;
      if (cmd_ready[g] !== 1'b1) begin
        failures++;
        $display("FAIL ready_after_reset u%0d: got %b required 1", g, cmd_ready[g]);
      end
    end
  endtask

  task automatic test_write();
    cmd(0, 1'b1, 5'h01, 5'h00, 16'h8000, "write_vec");
  endtask

  task automatic test_read();
    cmd(0, 1'b0, 5'($urandom), 5'h02, 16'h7949, "read_vec");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      cmd(0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    logic [4:0] p2, r2;
    logic [15:0] d2;
    p2 = 5'($urandom); r2 = 5'($urandom); d2 = 16'($urandom);
    do_cmd(0, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b1, p2, r2, d2, "b2b_first");
    do_cmd(0, 1'b1, p2, r2, d2, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 16'd0, "b2b_second");
    checks++;
    if (first_low[0] < 2 * dv(0)) begin
      failures++;
      $display("FAIL b2b_idle_low: got %0d cycles required >= %0d", first_low[0], 2 * dv(0));
    end
  endtask

  task automatic test_reset_abort();
    int t, rc;
    @(negedge clk);
    phy_len[0] = 64; phy_data[0] = 16'($urandom);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_phy[0] = 5'($urandom); cmd_reg[0] = 5'($urandom);
    t = 0;
    while (cmd_ready[0] !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    t = 0;
    while (nrise[0] < 40 && t < 5000) begin @(negedge clk); t++; end
    checks++;
    if (nrise[0] < 40) begin
      failures++;
      $display("FAIL abort_reach_bit40: got %0d periods required 40", nrise[0]);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mdc[0] !== 1'b0 || mdio_oe[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_immediate: mdc=%b oe=%b busy=%b required 0/0/0", mdc[0], mdio_oe[0], busy[0]);
    end
    rc = rsp_cnt[0];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (rsp_cnt[0] != rc) begin
      failures++;
      $display("FAIL abort_no_rsp: %0d pulses required 0", rsp_cnt[0] - rc);
    end
    checks++;
    if (rsp_rdata[0] !== 16'h0000) begin
      failures++;
      $display("FAIL abort_rdata_cleared: got %h required 0000", rsp_rdata[0]);
    end
    cmd(0, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), "after_abort");
  endtask

  task automatic test_macro();
    int exp2;
`ifdef MDIO_PRE_SUPPRESS_EN
    exp2 = 32;
`else
    exp2 = 64;
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    cmd(0, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), "macro_first");
    checks++;
    if (nrise[0] !== 64) begin
      failures++;
      $display("FAIL macro_first_len: got %0d required 64", nrise[0]);
    end
    cmd(0, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), "macro_second");
    checks++;
    if (nrise[0] !== exp2) begin
      failures++;
      $display("FAIL macro_second_len: got %0d required %0d", nrise[0], exp2);
    end
  endtask

  task automatic test_div25();
    cmd(1, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), "div25_write");
    cmd(1, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom), "div25_read");
  endtask

  task automatic test_timing();
    for (int g = 0; g < NU; g++) begin
      checks++;
      if (terr[g] != 0) begin
        failures++;
        $display("FAIL timing u%0d: %0d violations required 0", g, terr[g]);
      end
    end
  endtask

  initial begin
    for (int g = 0; g < NU; g++) begin
      cmd_valid[g] = 1'b0; cmd_write[g] = 1'b0; cmd_phy[g] = '0; cmd_reg[g] = '0; cmd_wdata[g] = '0;
      phy_data[g] = '0; phy_len[g] = 64;
    end
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_macro();
    test_div25();
    test_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
